// File: rtl/ila_sample_capture.sv
// ila_sample_capture: ring-buffer probe capture with mask/value trigger and oldest-first readout
module ila_sample_capture #(
    parameter int SAMPLE_WIDTH = 25,
    parameter int DEPTH_LOG2   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    arm,
    input  logic [DEPTH_LOG2-1:0]   pretrig,
    input  logic [SAMPLE_WIDTH-1:0] trig_value,
    input  logic [SAMPLE_WIDTH-1:0] trig_mask,
    input  logic                    trig_mode,
    input  logic                    rd_en,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,
    output logic                    armed,
    output logic                    triggered,
    output logic                    done
);
    typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;
    state_t state, state_n;
    logic [SAMPLE_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr, cnt, pre_n;
    logic match, match_d, trig, wr, rd;
    assign match     = ((sample_in ^ trig_value) & trig_mask) == '0;
    assign trig      = trig_mode ? match & ~match_d : match;
    assign wr        = state inside {PRE, WAIT_TRIG, POST};
    assign rd        = state == DONE && rd_en && !rd_last;
    assign armed     = wr;
    assign triggered = state inside {POST, DONE};
    assign done      = state == DONE;
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (arm) state_n = pretrig != '0 ? PRE : WAIT_TRIG;
            PRE:       if (cnt == pre_n - 1'b1) state_n = WAIT_TRIG;
            WAIT_TRIG: if (trig) state_n = &pre_n ? DONE : POST;
            POST:      if (cnt == ~pre_n - 1'b1) state_n = DONE;
            DONE:      if (rd_last) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= sample_in;
    end
    // the window is exactly DEPTH samples, so at DONE the oldest one sits at wr_ptr
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            cnt      <= '0;
            pre_n    <= '0;
            match_d  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            match_d  <= match;
            rd_valid <= rd;
            rd_last  <= rd && &cnt;
            if (rd) rd_data <= mem[wr_ptr];
            if (state == IDLE && arm) begin
                pre_n  <= pretrig;
                wr_ptr <= '0;
                cnt    <= '0;
            end
            if (wr || rd) wr_ptr <= wr_ptr + 1'b1;
            if (state inside {PRE, POST} || rd) cnt <= state_n != state ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ila_sample_capture.sv
// tb_ila_sample_capture: directed checks of capture, trigger modes, clamp, reset and readout
module tb_ila_sample_capture;
    localparam int W = 25, DL = 4, D = 16;
    logic clk = 1'b0, rst = 1'b0, arm = 1'b0, trig_mode = 1'b0, rd_en = 1'b0;
    logic [W-1:0] sample_in = '0, trig_value = '0, trig_mask = '0;
    logic [DL-1:0] pretrig = '0;
    logic [W-1:0] rd_data;
    logic rd_valid, rd_last, armed, triggered, done;
    int total = 0, bad = 0, trig_at;
    int exp_q [D];
    bit counting = 0;

    ila_sample_capture #(.SAMPLE_WIDTH(W), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .arm(arm), .pretrig(pretrig),
        .trig_value(trig_value), .trig_mask(trig_mask), .trig_mode(trig_mode),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .armed(armed), .triggered(triggered), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (counting) sample_in = sample_in + 1'b1;
    endtask

    task automatic start(input int pt, input logic md, input logic [W-1:0] mk, input logic [W-1:0] vl, input bit cnt_mode);
        counting   = 0;
        pretrig    = pt[DL-1:0];
        trig_mode  = md;
        trig_mask  = mk;
        trig_value = vl;
        trig_at    = -1;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        if (cnt_mode) sample_in = '0;
        counting = cnt_mode;
        chk("armed_after_arm", armed, 1);
    endtask

    task automatic wait_done(input int limit, input bit pulse, input bit rden);
        int n = 0;
        rd_en = rden;
        while (!done && n < limit) begin
            arm = pulse && (n == 8 || n == 20);
            tick;
            n++;
            if (triggered && trig_at < 0) trig_at = int'(sample_in) - 1;
            if (rden) chk("rd_valid_capture", rd_valid, 0);
        end
        arm = 1'b0;
        rd_en = 1'b0;
        counting = 0;
        chk("done_reached", done, 1);
    endtask

    task automatic fill_exp(input int first);
        for (int k = 0; k < D; k++) exp_q[k] = first + k;
    endtask

    task automatic read_burst(input int gap);
        for (int k = 0; k < D; k++) begin
            rd_en = 1'b1;
            tick;
            rd_en = 1'b0;
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, exp_q[k]);
            chk("rd_last", rd_last, k == D - 1);
            if (k < D - 1) repeat (gap) begin
                tick;
                chk("rd_valid_gap", rd_valid, 0);
            end
        end
        chk("done_on_last", done, 1);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        chk("done_drop", done, 0);
        chk("trig_drop", triggered, 0);
        chk("rd_valid_extra", rd_valid, 0);
    endtask

    task automatic post_fill(input int n);
        for (int k = 0; k < n; k++) begin
            sample_in = W'(100 + k);
            tick;
        end
    endtask

    initial begin
        tick;
        tick;
        chk("rst_armed", armed, 0);
        chk("rst_trig", triggered, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_last", rd_last, 0);
        chk("rst_data", rd_data, 0);
        rst = 1'b1;
        tick;

        start(4, 0, 25'h1FFFFFF, 25'h10, 1);
        wait_done(200, 0, 0);
        chk("s1_trig_at", trig_at, 16);
        fill_exp(12);
        read_burst(0);

        start(0, 0, 25'h1FFFFFF, 25'h5, 1);
        chk("s2_no_pre_armed", armed, 1);
        wait_done(200, 0, 0);
        chk("s2_trig_at", trig_at, 5);
        fill_exp(5);
        read_burst(0);

        sample_in = 25'h8;
        tick;
        start(2, 1, 25'h8, 25'h8, 0);
        repeat (5) tick;
        chk("s3_held_no_trig", triggered, 0);
        sample_in = '0;
        tick;
        chk("s3_low_no_trig", triggered, 0);
        sample_in = 25'h8;
        tick;
        chk("s3_rise_trig", triggered, 1);
        post_fill(13);
        chk("s3_done", done, 1);
        exp_q[0] = 8; exp_q[1] = 0; exp_q[2] = 8;
        for (int k = 3; k < D; k++) exp_q[k] = 100 + k - 3;
        read_burst(0);

        sample_in = 25'h8;
        tick;
        start(2, 0, 25'h8, 25'h8, 0);
        tick;
        tick;
        chk("s3l_pre_no_trig", triggered, 0);
        tick;
        chk("s3l_first_wait_trig", triggered, 1);
        post_fill(13);
        chk("s3l_done", done, 1);
        exp_q[0] = 8; exp_q[1] = 8; exp_q[2] = 8;
        for (int k = 3; k < D; k++) exp_q[k] = 100 + k - 3;
        read_burst(0);

        start(20, 0, 25'h1FFFFFF, 25'h10, 1);
        wait_done(200, 0, 0);
        chk("s4_wrap_trig_at", trig_at, 16);
        fill_exp(12);
        read_burst(0);

        start(15, 0, 25'h1FFFFFF, 25'd30, 1);
        wait_done(200, 0, 0);
        chk("s4_clamp_trig_at", trig_at, 30);
        fill_exp(15);
        read_burst(0);

        start(3, 0, 25'h0, 25'h0, 1);
        wait_done(200, 0, 0);
        chk("zero_mask_trig_at", trig_at, 3);
        fill_exp(0);
        read_burst(0);

        start(4, 0, 25'h1FFFFFF, 25'h10, 1);
        for (int n = 0; n < 200 && !triggered; n++) tick;
        chk("s5_triggered", triggered, 1);
        repeat (3) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        chk("s5_armed", armed, 0);
        chk("s5_trig", triggered, 0);
        chk("s5_done", done, 0);
        chk("s5_valid", rd_valid, 0);
        start(4, 0, 25'h1FFFFFF, 25'h10, 1);
        wait_done(200, 0, 0);
        chk("s5_trig_at", trig_at, 16);
        fill_exp(12);
        read_burst(0);

        start(4, 0, 25'h1FFFFFF, 25'h10, 1);
        wait_done(200, 1, 1);
        chk("s6_trig_at", trig_at, 16);
        fill_exp(12);
        read_burst(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ila_sample_capture.md
Name: ila_sample_capture

Overview:
Downstream consumer of the DUT probe vector; for example, the 25-bit blink counter is driven as sample_in. Behaviour in brief:
- Captures sample_in into an on-chip ring buffer every clock once armed.
- Waits for a mask/value trigger, level or rising-match.
- Freezes a window of DEPTH samples, of which PRETRIG precede the trigger.
- Replays the window oldest-first over a simple read handshake to the ILA readout logic.

Parameters:
SAMPLE_WIDTH, 25, probe vector width
DEPTH_LOG2, 10, log2 of buffer depth; DEPTH = 2**DEPTH_LOG2

Ports:
clk  in  1  single capture/read clock
rst  in  1  synchronous active-low reset (0 = reset), sampled on posedge clk
sample_in  in  SAMPLE_WIDTH  probe vector from DUT
arm  in  1  start capture; honoured only in IDLE
pretrig  in  DEPTH_LOG2  requested pre-trigger sample count, latched at arm
trig_value  in  SAMPLE_WIDTH  trigger compare value
trig_mask  in  SAMPLE_WIDTH  1 = bit participates in compare
trig_mode  in  1  0 = level match, 1 = rising match
rd_en  in  1  request one readout beat; honoured only in DONE
rd_data  out  SAMPLE_WIDTH  readout sample
rd_valid  out  1  rd_data valid
rd_last  out  1  marks beat DEPTH of readout
armed  out  1  high in PRE/WAIT_TRIG/POST
triggered  out  1  high in POST/DONE
done  out  1  high in DONE

Behaviour:
- Reset state: rst=0 at posedge gives state IDLE and clears the following.
  - armed=0, triggered=0, done=0.
  - rd_valid=0, rd_last=0, rd_data=0.
  - Pointers, counters and match_d are cleared to 0.
  - Buffer contents are not cleared.
- Reset applies from any state, including mid-capture and mid-readout.
- match = (((sample_in ^ trig_value) & trig_mask) == 0).
  - match_d is match registered every cycle in every state.
  - Trigger condition: trig_mode=0 gives match; trig_mode=1 gives match & ~match_d.
- Write rule:
  - In PRE, WAIT_TRIG and POST, every cycle writes sample_in to mem[wr_ptr].
  - wr_ptr then increments modulo DEPTH; wrap is silent.
  - No writes occur in IDLE or DONE.
- States:
  - IDLE:
    - arm=1 latches pre_n = min(pretrig, DEPTH-1) and sets wr_ptr=0, fill=0.
    - Goes to PRE if pre_n>0, else to WAIT_TRIG.
  - PRE:
    - Writes samples and counts them in fill.
    - Triggers are ignored.
    - When fill reaches pre_n (after pre_n writes), goes to WAIT_TRIG.
  - WAIT_TRIG:
    - On trigger, the sample written that same cycle is the trigger sample; trig_addr = wr_ptr.
    - post_n = DEPTH-1-pre_n.
    - Goes to DONE if post_n=0, else to POST.
    - Without a trigger, the ring keeps overwriting with no timeout.
  - POST:
    - Writes post_n further samples, then goes to DONE.
  - DONE:
    - rd_ptr = (trig_addr - pre_n) mod DEPTH; rd_cnt=0.
    - Each rd_en=1 cycle reads mem[rd_ptr] and increments rd_ptr mod DEPTH.
    - rd_valid/rd_data appear exactly 1 cycle later; back-to-back rd_en gives one beat per cycle.
    - rd_last=1 with beat DEPTH.
    - The cycle after the rd_last beat, state returns to IDLE: done=0, triggered=0.
    - rd_en beyond the last beat is ignored.
- Ignored inputs: arm outside IDLE is ignored; rd_en outside DONE produces no rd_valid.
- All-zero trig_mask with trig_mode=0 triggers on the first WAIT_TRIG cycle.
- trig_mode=1 with the signal already matching on WAIT_TRIG entry (match_d=1) does not trigger until match falls and rises again.
- Buffer: single-port-per-side memory (1 write, 1 registered read) that must map to block RAM.

Test Plan:
Bench setup: DEPTH_LOG2=4 (DEPTH=16), SAMPLE_WIDTH=25. sample_in is a free-running counter equal to 0 in the first cycle after arm, +1 per cycle.
1. pretrig=4, trig_mode=0, mask=0x1FFFFFF, value=0x10.
   - Trigger on sample 16.
   - 16 back-to-back rd_en give rd_data 12..27, rd_last only on 27.
   - done then drops the cycle after the last beat.
2. pretrig=0, value=5.
   - State goes IDLE to WAIT_TRIG directly.
   - Readout 5..20; triggered=1 from the cycle after sample 5.
3. pretrig=2, trig_mode=1, mask=0x8, value=0x8, with sample_in held at 0x8 through arm/PRE.
   - No trigger while held.
   - Drive 0, then 0x8: trigger on that 0x8 sample, which is readout beat 3.
   - Level mode (trig_mode=0) with the same stimulus triggers on the first WAIT_TRIG cycle.
4. pretrig=20 (masked to DEPTH_LOG2 bits = 4) vs pretrig=15.
   - Check clamp semantics: pretrig=15 with value=30 gives readout 15..30.
   - The trigger is the last beat (post_n=0), with rd_last on 30.
5. Assert rst=0 for 1 cycle mid-POST.
   - Next cycle armed=0, triggered=0, done=0, rd_valid=0.
   - A subsequent arm with the scenario 1 setup reproduces the scenario 1 result exactly.
6. Ignored inputs:
   - arm pulses during WAIT_TRIG and POST do not restart capture (pointer continuity checked via readout values).
   - rd_en in IDLE/PRE/WAIT_TRIG/POST never asserts rd_valid.
   - In DONE, rd_en with 1-cycle gaps gives rd_valid exactly 1 cycle after each rd_en.
